shared_pipe_arb: RTL

SHARED_PIPE_ARB -- requirements
Module: shared_pipe_arb

---
 rtl/shared_pipe_arb_pkg.sv | 35 +++
 rtl/shared_pipe_arb_pipe_stage.sv | 46 ++++
 rtl/shared_pipe_arb.sv | 110 +++++++++++
 3 files changed

// File: rtl/shared_pipe_arb_pkg.sv
// Shared definitions for the two-requester arbitrated pipeline:
// default sizing, the depth ceiling, the requester-id type and the
// round-robin pick used by the arbiter.
package shared_pipe_arb_pkg;

   // Default width of one data word.
   localparam int DATA_W_DEF = 8;

   // Default number of register stages in the shared pipeline.
   localparam int DEPTH_DEF  = 2;

   // Largest supported pipeline depth.
   localparam int DEPTH_MAX  = 8;

   // Identifies which requester a word came from (0 or 1).
   typedef logic req_id_t;

   // Round-robin winner between two requesters. A lone valid requester
   // always wins; on a tie the one that did not win last time is chosen.
   // With no valid requester the result is irrelevant and defaults to 0.
   function automatic req_id_t rr_pick(input logic    i_v0,
                                       input logic    i_v1,
                                       input req_id_t i_last);
      req_id_t w_win;
      if (i_v0 && i_v1) begin
         w_win = ~i_last;
      end else if (i_v1) begin
         w_win = 1'b1;
      end else begin
         w_win = 1'b0;
      end
      return w_win;
   endfunction

endpackage

// File: rtl/shared_pipe_arb_pipe_stage.sv
// One stage of the shared pipeline: a valid bit plus the data word and
// its requester id. The valid bit has a synchronous clear that wins over
// the load enable; data and id carry no reset because they are only
// meaningful while valid is set.
module pipe_stage
   import shared_pipe_arb_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              i_clr,
   input  logic              i_load,
   input  logic              i_vld,
   input  logic [DATA_W-1:0] i_data,
   input  req_id_t           i_id,
   output logic              o_vld,
   output logic [DATA_W-1:0] o_data,
   output req_id_t           o_id
);

   logic              r_vld;
   logic [DATA_W-1:0] r_data;
   req_id_t           r_id;

   // Valid bit: cleared by reset, otherwise follows the upstream valid on load.
   always_ff @(posedge clk) begin
      if (i_clr) begin
         r_vld <= 1'b0;
      end else if (i_load) begin
         r_vld <= i_vld;
      end
   end

   // Payload: captured on every load, held while the pipeline stalls.
   always_ff @(posedge clk) begin
      if (i_load) begin
         r_data <= i_data;
         r_id   <= i_id;
      end
   end

   assign o_vld  = r_vld;
   assign o_data = r_data;
   assign o_id   = r_id;

endmodule

// File: rtl/shared_pipe_arb.sv
// Two requesters share one DEPTH-stage pipeline. A round-robin arbiter
// picks which requester may load stage 0; the whole pipeline shifts in
// lock-step whenever the last stage is empty or being drained, and holds
// entirely otherwise (no bubble squeezing). Every word carries the index
// of the requester that sent it.
module shared_pipe_arb
   import shared_pipe_arb_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = DEPTH_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0_valid,
   input  logic [DATA_W-1:0] req0_data,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic [DATA_W-1:0] req1_data,
   output logic              req1_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output req_id_t           out_id,
   input  logic              out_ready,
   output logic              busy
);

   // Requester that won the most recent transfer; a tie goes to the other one.
   req_id_t           r_last_grant;

   // Stage outputs.
   logic [DEPTH-1:0]  w_stg_vld;
   logic [DATA_W-1:0] w_stg_data [DEPTH];
   req_id_t           w_stg_id   [DEPTH];

   // Stage inputs: stage 0 from the arbiter, stage N+1 from stage N.
   logic [DEPTH-1:0]  w_in_vld;
   logic [DATA_W-1:0] w_in_data  [DEPTH];
   req_id_t           w_in_id    [DEPTH];

   logic              w_last_vld;
   logic              w_advance;
   req_id_t           w_grant;
   logic              w_rdy0;
   logic              w_rdy1;
   logic              w_xfer;
   logic [DATA_W-1:0] w_grant_data;

   // The pipeline moves only as a whole: when the output slot is free or
   // is being consumed this cycle.
   assign w_last_vld = w_stg_vld[DEPTH-1];
   assign w_advance  = !w_last_vld || out_ready;

   // The grant is decided from the current valids alone; readiness then
   // qualifies it with advance, so a stalled pipe grants nothing and the
   // round-robin pointer stays put.
   assign w_grant = rr_pick(req0_valid, req1_valid, r_last_grant);

   // Reset suppresses both readies so no word can slip in on a reset edge.
   assign w_rdy0 = !rst && w_advance && (w_grant == 1'b0) && req0_valid;
   assign w_rdy1 = !rst && w_advance && (w_grant == 1'b1) && req1_valid;
   assign w_xfer = w_rdy0 || w_rdy1;

   assign w_grant_data = (w_grant == 1'b1) ? req1_data : req0_data;

   // Round-robin pointer: moves to the winner only when a word is accepted.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_last_grant <= 1'b1;
      end else if (w_xfer) begin
         r_last_grant <= w_grant;
      end
   end

   // Stage 0 takes the granted word, or a bubble when nothing transferred.
   assign w_in_vld[0]  = w_xfer;
   assign w_in_data[0] = w_grant_data;
   assign w_in_id[0]   = w_grant;

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      if (gi > 0) begin : g_chain
         assign w_in_vld[gi]  = w_stg_vld[gi-1];
         assign w_in_data[gi] = w_stg_data[gi-1];
         assign w_in_id[gi]   = w_stg_id[gi-1];
      end

      pipe_stage #(
         .DATA_W (DATA_W)
      ) u_stage (
         .clk    (clk),
         .i_clr  (rst),
         .i_load (w_advance),
         .i_vld  (w_in_vld[gi]),
         .i_data (w_in_data[gi]),
         .i_id   (w_in_id[gi]),
         .o_vld  (w_stg_vld[gi]),
         .o_data (w_stg_data[gi]),
         .o_id   (w_stg_id[gi])
      );
   end

   // Status outputs are masked by reset so they read 0 in the reset cycle
   // itself, not only after the clearing edge.
   assign req0_ready = w_rdy0;
   assign req1_ready = w_rdy1;
   assign out_valid  = w_last_vld && !rst;
   assign out_data   = w_stg_data[DEPTH-1];
   assign out_id     = w_stg_id[DEPTH-1];
   assign busy       = (|w_stg_vld) && !rst;

endmodule
